// File: rtl/parity_frame_pkg.sv
// Frame layout constants and the payload-to-frame encoder shared by the
// parity frame generator and its FIFO.
package parity_frame_pkg;

  localparam int MARKER_BIT     = 15;
  localparam int NARROW_PAR_BIT = 8;
  localparam int WIDE_PAR_BIT   = 0;
  localparam int NARROW_W       = 8;
  localparam int WIDE_W         = 14;

  typedef logic [15:0] frame_t;

  // Even parity over payload bits only; invert flips it for fault injection.
  function automatic frame_t calc_frame(input logic              wide,
                                        input logic [WIDE_W-1:0] payload,
                                        input logic              invert);
    frame_t f;
    f = '0;
    if (wide) begin
      f[MARKER_BIT]     = 1'b1;
      f[WIDE_W:1]       = payload;
      f[WIDE_PAR_BIT]   = (^payload) ^ invert;
    end else begin
      f[NARROW_W-1:0]   = payload[NARROW_W-1:0];
      f[NARROW_PAR_BIT] = (^payload[NARROW_W-1:0]) ^ invert;
    end
    return f;
  endfunction

endpackage

// File: rtl/parity_frame_fifo.sv
// Show-ahead FIFO with registered storage; DEPTH must be a power of two.
// The head entry is visible on data_o whenever the FIFO is not empty.
module parity_frame_fifo
  import parity_frame_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  logic   pop_i,
  input  frame_t data_i,
  output frame_t data_o,
  output logic   full_o,
  output logic   empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  frame_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Empty FIFO shows zero so the output is defined straight out of reset.
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // NOTE: storage is not reset; the count gates visibility, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/parity_frame_generator.sv
// Appends even parity to 8/14-bit payloads, frames them and buffers them.
// Define PARITY_INJECT_EN to add inject_req/inj_cnt parity fault injection.
module parity_frame_generator
  import parity_frame_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wide,
  input  logic [WIDE_W-1:0] in_payload,
  output logic              out_valid,
  input  logic              out_ready,
  output frame_t            out_frame,
  output logic [CNT_W-1:0]  frame_cnt
`ifdef PARITY_INJECT_EN
  ,
  input  logic              inject_req,
  output logic [7:0]        inj_cnt
`endif
);

  logic   full, empty, push, pop, invert;
  frame_t enc_frame;
  logic [CNT_W-1:0] frame_cnt_q;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign enc_frame = calc_frame(in_wide, in_payload, invert);
  assign frame_cnt = frame_cnt_q;

  parity_frame_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (enc_frame),
    .data_o  (out_frame),
    .full_o  (full),
    .empty_o (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_cnt_q <= '0;
    else if (pop) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
  end

`ifdef PARITY_INJECT_EN
  logic       arm_q, arm_d;
  logic [7:0] inj_cnt_q, inj_cnt_d;

  // A pulse in the same cycle as an accept corrupts that very payload.
  assign invert  = arm_q || inject_req;
  assign inj_cnt = inj_cnt_q;

  always_comb begin
    arm_d     = arm_q;
    inj_cnt_d = inj_cnt_q;
    if (push && invert) begin
      arm_d = 1'b0;
      if (inj_cnt_q != 8'hFF) inj_cnt_d = inj_cnt_q + 8'd1;
    end else if (inject_req) begin
      arm_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      arm_q     <= 1'b0;
      inj_cnt_q <= '0;
    end else begin
      arm_q     <= arm_d;
      inj_cnt_q <= inj_cnt_d;
    end
  end
`else
  assign invert = 1'b0;
`endif

endmodule

// File: doc/parity_frame_generator.md
# parity_frame_generator

Upstream framing stage for the parity checking path. Accepts raw payloads (8-bit narrow or 14-bit wide) over a valid/ready handshake and appends an even-parity bit. Packs each payload into the 16-bit frame format consumed by the downstream parity checker. Buffers frames in a small FIFO so producer bursts are decoupled from consumer stalls.

## Interface
- DEPTH, 4: FIFO entries; power of two, 2..16.
- CNT_W, 16: width of the frame counter.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  payload offered.
- in_ready  output  1  block can accept a payload this cycle.
- in_wide  input  1  1 = 14-bit wide payload, 0 = 8-bit narrow payload.
- in_payload  input  14  payload. Narrow mode uses bits [7:0]; bits [13:8] are ignored.
- out_valid  output  1  out_frame holds a frame.
- out_ready  input  1  consumer takes the frame this cycle.
- out_frame  output  16  encoded frame.
- frame_cnt  output  CNT_W  frames delivered (out_valid && out_ready), wraps.
- inject_req  input  1  present only with PARITY_INJECT_EN.
- inj_cnt  output  8  present only with PARITY_INJECT_EN.

## Operation
- p = XOR of payload bits only. Narrow mode uses [7:0]; wide mode uses [13:0]. The marker bit is excluded.
- Narrow frame: bit15 = 0, bits [14:9] = 0, bit8 = p, bits [7:0] = payload.
- Wide frame: bit15 = 1, bits [14:1] = payload[13:0], bit0 = p.
- A payload is accepted when in_valid && in_ready. It is encoded combinationally and written to the FIFO already framed.
- The FIFO is show-ahead with registered storage. out_frame is the head entry.
- out_valid = !empty. in_ready = !full.
- The FIFO holds exactly DEPTH frames. in_ready is computed from the current fill level only, so a same-cycle pop does not raise in_ready.
- Simultaneous push and pop when neither full nor empty: the count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. The count is $clog2(DEPTH)+1 bits wide.
- frame_cnt increments on every delivery and wraps from all-ones to 0.
- in_payload and in_wide are sampled only on acceptance. Changing them while in_valid is high and in_ready is low is legal.

## Timing
- Reset values: out_valid = 0, in_ready = 1, out_frame = 16'h0000, frame_cnt = 0, inj_cnt = 0. The FIFO is empty and the injection arm is clear.
- Latency: a payload accepted in cycle N gives out_valid = 1 in cycle N+1 when the FIFO was empty.
- out_frame and out_valid stay stable while out_valid && !out_ready.
- Full: in_ready falls in the cycle after the DEPTH-th accept. It rises in the cycle after the first pop.
- Empty: out_valid falls in the cycle after the last pop unless a push occurs in the same cycle.
- Reset asserted mid-burst flushes all entries immediately and asynchronously. No partial frame survives.
- Throughput is one frame per cycle in each direction.

## Configuration
- PARITY_INJECT_EN defined:
  - inject_req and inj_cnt exist.
  - A 1-cycle inject_req pulse sets a sticky arm.
  - The next accepted payload, including one accepted in the same cycle as the pulse, is written with its parity bit inverted. The arm then clears and inj_cnt increments, saturating at 8'hFF.
  - Further pulses while armed have no additional effect.
- PARITY_INJECT_EN undefined:
  - The ports, arm register and counter are absent.
  - Frames always carry correct even parity.

## Structure
- Package parity_frame_pkg contains:
  - Frame layout constants: MARKER_BIT = 15, NARROW_PAR_BIT = 8, WIDE_PAR_BIT = 0, NARROW_W = 8, WIDE_W = 14.
  - typedef logic [15:0] frame_t.
  - Function calc_frame(wide, payload, invert) returning frame_t.
- Sub-module parity_frame_fifo holds the DEPTH-entry show-ahead FIFO with push/pop/full/empty. The top level contains encoding, counters and injection.

## Test plan
- Reset, then narrow payload 8'hA5 -> out_frame = 16'h00A5 with out_valid one cycle after accept. Narrow 8'h07 -> 16'h0107.
- Wide payload 14'h0001 -> 16'h8003. Wide 14'h3FFF -> 16'hFFFE.
- out_ready held 0, push 5 payloads with DEPTH = 4 -> in_ready goes low after the 4th accept. The 5th payload is held off until one pop, then accepted. Frames are delivered in order and frame_cnt = 5.
- Continuous push and pop at full rate for 20 frames -> no bubbles after the first frame and frame_cnt = 20. With CNT_W = 4, frame_cnt shows 4 after wrap.
- Assert rst_n low with 3 frames buffered -> out_valid = 0 and frame_cnt = 0 immediately. After release, a new payload 8'h01 gives 16'h0101.
- With PARITY_INJECT_EN, pulse inject_req, then push 8'hA5 and 8'hA5 -> frames are 16'h01A5 then 16'h00A5, and inj_cnt = 1.
